// File: rtl/skip_borrow_subtractor.sv
// Iterative block-serial subtractor: diff = a - b - bin, one BLK-bit block per
// clock, LSB block first, with block-level borrow skip and a skip counter.
module skip_borrow_subtractor #(
  parameter  int N   = 32,
  parameter  int BLK = 4,
  localparam int NB  = N / BLK,
  localparam int CW  = $clog2(NB) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  a,
  input  logic [N-1:0]  b,
  input  logic          bin,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  diff,
  output logic          bout,
  output logic          OF,
  output logic [CW-1:0] skip_cnt
);

  localparam int IW = (NB > 1) ? $clog2(NB) : 1;

  generate
    if ((N % BLK) != 0 || BLK < 1) begin : g_cfg_err
      $error("skip_borrow_subtractor: N must be a positive multiple of BLK");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_n;
  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [N-1:0]    r_diff;
  logic            r_borrow;
  logic            r_bout;
  logic            r_of;
  logic            r_out_valid;
  logic [IW-1:0]   r_idx;
  logic [CW-1:0]   r_skip_cnt;

  logic [31:0]     w_base;
  logic [BLK-1:0]  w_a_blk;
  logic [BLK-1:0]  w_b_blk;
  logic [BLK:0]    w_blk_sub;
  logic            w_prop;
  logic            w_borrow_n;
  logic            w_last;

  assign w_base     = 32'(r_idx) * 32'(BLK);
  assign w_a_blk    = r_a[w_base +: BLK];
  assign w_b_blk    = r_b[w_base +: BLK];
  // Extra MSB of the widened difference is the ripple borrow-out of the block.
  assign w_blk_sub  = {1'b0, w_a_blk} - {1'b0, w_b_blk} - {{BLK{1'b0}}, r_borrow};
  assign w_prop     = &(w_a_blk ~^ w_b_blk);
  assign w_borrow_n = w_prop ? r_borrow : w_blk_sub[BLK];
  assign w_last     = (r_idx == IW'(NB - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE: if (in_valid)                  w_state_n = S_RUN;
      S_RUN:  if (w_last)                    w_state_n = S_DONE;
      S_DONE: if (r_out_valid && out_ready)  w_state_n = S_IDLE;
      default:                               w_state_n = S_IDLE;
    endcase
  end

  // DONE is entered with out_valid low; the first DONE cycle registers OF
  // from the completed diff, so out_valid rises one edge after the last block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_diff      <= '0;
      r_borrow    <= 1'b0;
      r_bout      <= 1'b0;
      r_of        <= 1'b0;
      r_out_valid <= 1'b0;
      r_idx       <= '0;
      r_skip_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= b;
            r_borrow   <= bin;
            r_idx      <= '0;
            r_skip_cnt <= '0;
          end
        end
        S_RUN: begin
          r_diff[w_base +: BLK] <= w_blk_sub[BLK-1:0];
          r_borrow              <= w_borrow_n;
          if (w_prop) begin
            r_skip_cnt <= r_skip_cnt + CW'(1);
          end
          if (w_last) begin
            r_idx  <= '0;
            r_bout <= w_borrow_n;
          end else begin
            r_idx  <= r_idx + IW'(1);
          end
        end
        S_DONE: begin
          if (!r_out_valid) begin
            r_of        <= (r_a[N-1] != r_b[N-1]) && (r_diff[N-1] != r_a[N-1]);
            r_out_valid <= 1'b1;
          end else if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign bout      = r_bout;
  assign OF        = r_of;
  assign skip_cnt  = r_skip_cnt;

endmodule

// File: tb/tb_skip_borrow_subtractor.sv
module tb_skip_borrow_subtractor;

  localparam int N   = 32;
  localparam int BLK = 4;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          bin;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  diff;
  logic          bout;
  logic          OF;
  logic [CW-1:0] skip_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  skip_borrow_subtractor #(.N(N), .BLK(BLK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .OF        (OF),
    .skip_cnt  (skip_cnt)
  );

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (diff !== 32'h0) begin bad++; $display("FAIL reset_diff got=%h exp=0", diff); end
    total++; if ({bout, OF} !== 2'b00) begin bad++; $display("FAIL reset_bout_of got=%b exp=00", {bout, OF}); end
    total++; if (skip_cnt !== 4'd0) begin bad++; $display("FAIL reset_skip got=%0d exp=0", skip_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Offers one operand set, checks acceptance, RUN-time in_ready and latency.
  task automatic start_and_wait(input string name, input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                                input logic tbin);
    int n;
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL %s idle_in_ready got=%b exp=1", name, in_ready); end
    a = ta; b = tb_v; bin = tbin; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; bin = 1'b1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL %s run_in_ready got=%b exp=0", name, in_ready); end
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    total++; if (n != 9) begin bad++; $display("FAIL %s latency got=%0d exp=9", name, n); end
  endtask

  task automatic check_result(input string name, input logic [N-1:0] ed, input logic eb,
                              input logic eo, input logic [CW-1:0] es);
    total++; if (diff !== ed) begin bad++; $display("FAIL %s diff got=%h exp=%h", name, diff, ed); end
    total++; if (bout !== eb) begin bad++; $display("FAIL %s bout got=%b exp=%b", name, bout, eb); end
    total++; if (OF !== eo) begin bad++; $display("FAIL %s OF got=%b exp=%b", name, OF, eo); end
    total++; if (skip_cnt !== es) begin bad++; $display("FAIL %s skip_cnt got=%0d exp=%0d", name, skip_cnt, es); end
  endtask

  task automatic handshake(input string name);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s post_hs_out_valid got=%b exp=0", name, out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL %s post_hs_in_ready got=%b exp=1", name, in_ready); end
  endtask

  task automatic test_vector(input string name, input logic [N-1:0] ta, input logic [N-1:0] tb_v,
                             input logic tbin, input logic [N-1:0] ed, input logic eb,
                             input logic eo, input logic [CW-1:0] es);
    start_and_wait(name, ta, tb_v, tbin);
    check_result(name, ed, eb, eo, es);
    handshake(name);
  endtask

  task automatic test_backpressure();
    start_and_wait("bp", 32'h0000_00FF, 32'h0000_000F, 1'b0);
    check_result("bp", 32'h0000_00F0, 1'b0, 1'b0, 4'd7);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = $urandom; b = $urandom; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk);
      #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_out_valid[%0d] got=%b exp=1", i, out_valid); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold_in_ready[%0d] got=%b exp=0", i, in_ready); end
      check_result("bp_hold", 32'h0000_00F0, 1'b0, 1'b0, 4'd7);
    end
    @(negedge clk);
    out_ready = 1'b1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_handoff_in_ready got=%b exp=0", in_ready); end
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_hs_out_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_hs_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset_midrun();
    @(negedge clk);
    a = 32'hFFFF_FFFF; b = 32'h1234_5678; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mrst_out_valid got=%b exp=0", out_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mrst_in_ready got=%b exp=1", in_ready); end
    total++; if (diff !== 32'h0) begin bad++; $display("FAIL mrst_diff got=%h exp=0", diff); end
    total++; if ({bout, OF, skip_cnt} !== 6'b0) begin bad++; $display("FAIL mrst_flags got=%b exp=0", {bout, OF, skip_cnt}); end
    @(negedge clk);
    rst_n = 1'b1;
    test_vector("after_rst", 32'd7, 32'd2, 1'b0, 32'd5, 1'b0, 1'b0, 4'd7);
  endtask

  initial begin
    test_reset();
    test_vector("5m3",      32'd5,          32'd3,          1'b0, 32'h0000_0002, 1'b0, 1'b0, 4'd7);
    test_vector("0m1",      32'd0,          32'd1,          1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'd7);
    test_vector("minm1",    32'h8000_0000,  32'd1,          1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 4'd6);
    test_vector("eq_bin",   32'h1234_5678,  32'h1234_5678,  1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'd8);
    test_vector("zero",     32'd0,          32'd0,          1'b0, 32'h0000_0000, 1'b0, 1'b0, 4'd8);
    test_vector("pos_ovf",  32'h7FFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'h8000_0000, 1'b1, 1'b1, 4'd7);
    test_backpressure();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
